conv_pe_engine: RTL and testbench

CONV_PE_ENGINE -- requirements
Module: conv_pe_engine

---
 rtl/conv_pe_engine_pkg.sv | 19 +
 rtl/pe_mac.sv | 44 ++++
 rtl/conv_pe_engine.sv | 117 +++++++++++
 tb/tb_conv_pe_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/conv_pe_engine_pkg.sv
// Shared constants and the state type for the 4x4 * 3x3 valid-convolution engine.
// DW/ACCW are the default widths; the array sizes and tap count are fixed
// by the 4x4 input / 3x3 filter / 2x2 output geometry.
package conv_pe_engine_pkg;

    localparam int DW    = 8;   // operand / result width
    localparam int ACCW  = 20;  // accumulator width (9*255*255 fits)
    localparam int IN_N  = 4;   // input is IN_N x IN_N
    localparam int FLT_N = 3;   // filter is FLT_N x FLT_N
    localparam int OUT_N = 2;   // output is OUT_N x OUT_N
    localparam int TAPS  = FLT_N * FLT_N;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pe_mac.sv
// Single multiply-accumulate lane: unsigned DW x DW product added to an
// ACCW-bit accumulator, with a saturated DW-bit view of the running sum.
// Ports:
//   clk, reset     - clock, async active-high reset
//   i_clr          - clear accumulator (start of a new computation)
//   i_en           - accumulate this cycle's product
//   i_last         - last tap of an output: sum is consumed, accumulator cleared
//   i_a, i_b       - operands
//   o_sum          - acc + product (combinational)
//   o_sat          - o_sum saturated to 2^DW-1
module pe_mac #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic            i_last,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [ACCW-1:0] o_sum,
    output logic [DW-1:0]   o_sat
);

    localparam logic [ACCW-1:0] SAT_MAX = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};

    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_prod;

    assign w_prod = ACCW'(i_a) * ACCW'(i_b);
    assign o_sum  = r_acc + w_prod;
    assign o_sat  = (o_sum > SAT_MAX) ? {DW{1'b1}} : o_sum[DW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (i_clr || (i_en && i_last))
            r_acc <= '0;
        else if (i_en)
            r_acc <= o_sum;
    end

endmodule

// File: rtl/conv_pe_engine.sv
// 2x2 valid convolution of a 4x4 input by a 3x3 filter, one MAC per cycle.
// A start in IDLE snapshots the operands; 36 MAC cycles later the four
// results are registered and done_o is held until active_store_i.
// Ports:
//   clk, reset          - clock, async active-high reset
//   start_i             - operands valid (only honoured in IDLE)
//   a_i                 - 4x4 input, row-major, a11 in the LSBs
//   b_i                 - 3x3 filter, row-major, b11 in the LSBs
//   active_store_i      - results consumed (only honoured in DONE)
//   busy_o, done_o      - computing / results valid
//   c11_o..c22_o        - saturated results, held until the next computation
module conv_pe_engine
    import conv_pe_engine_pkg::*;
#(
    parameter int DW   = conv_pe_engine_pkg::DW,
    parameter int ACCW = conv_pe_engine_pkg::ACCW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [IN_N*IN_N*DW-1:0]   a_i,
    input  logic [TAPS*DW-1:0]        b_i,
    input  logic                      active_store_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DW-1:0]             c11_o,
    output logic [DW-1:0]             c12_o,
    output logic [DW-1:0]             c21_o,
    output logic [DW-1:0]             c22_o
);

    localparam logic [3:0] TAP_LAST = 4'(TAPS - 1);

    state_t r_state, w_next;

    logic [IN_N*IN_N-1:0][DW-1:0]   r_a;
    logic [TAPS-1:0][DW-1:0]        r_b;
    logic [OUT_N*OUT_N-1:0][DW-1:0] r_c;
    logic [1:0]                     r_o;   // output index: row = r_o[1], col = r_o[0]
    logic [3:0]                     r_t;   // tap index 0..8

    logic [3:0]      w_ti, w_tj, w_row, w_aidx;
    logic            w_start, w_mac, w_last;
    logic [ACCW-1:0] w_sum;
    logic [DW-1:0]   w_sat;

    // Tap -> filter row/col; input element = (r+i)*4 + (c+j).
    // The filter element is simply r_t since the filter is row-major.
    assign w_ti   = r_t / 4'd3;
    assign w_tj   = r_t - w_ti * 4'd3;
    assign w_row  = {3'b0, r_o[1]} + w_ti;
    assign w_aidx = {w_row[1:0], 2'b00} + {3'b0, r_o[0]} + w_tj;

    assign w_start = (r_state == ST_IDLE) && start_i;
    assign w_mac   = (r_state == ST_MAC);
    assign w_last  = (r_t == TAP_LAST);

    pe_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start),
        .i_en   (w_mac),
        .i_last (w_last),
        .i_a    (r_a[w_aidx]),
        .i_b    (r_b[r_t]),
        .o_sum  (w_sum),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i)                  w_next = ST_MAC;
            ST_MAC:  if (w_last && (r_o == 2'd3))  w_next = ST_DONE;
            ST_DONE: if (active_store_i)           w_next = ST_IDLE;
            default:                               w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_o <= '0;
            r_t <= '0;
        end else if (w_start) begin
            r_a <= a_i;
            r_b <= b_i;
            r_o <= '0;
            r_t <= '0;
        end else if (w_mac) begin
            if (w_last) begin
                r_c[r_o] <= w_sat;
                r_t      <= '0;
                r_o      <= r_o + 2'd1;   // wraps to 0 after the last output
            end else begin
                r_t <= r_t + 4'd1;
            end
        end
    end

    assign busy_o = (r_state == ST_MAC);
    assign done_o = (r_state == ST_DONE);
    assign c11_o  = r_c[0];
    assign c12_o  = r_c[1];
    assign c21_o  = r_c[2];
    assign c22_o  = r_c[3];

endmodule

// File: tb/tb_conv_pe_engine.sv
module tb_conv_pe_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [127:0] a_i;
    logic [71:0]  b_i;
    logic         active_store_i;
    logic         busy_o, done_o;
    logic [7:0]   c11_o, c12_o, c21_o, c22_o;

    int checks = 0;
    int fails  = 0;

    conv_pe_engine #(.DW(8), .ACCW(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .active_store_i (active_store_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .c11_o          (c11_o),
        .c12_o          (c12_o),
        .c21_o          (c21_o),
        .c22_o          (c22_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain 2D valid convolution with saturation; results packed {c22,c21,c12,c11}.
    function automatic logic [31:0] ref_conv(input logic [127:0] a, input logic [71:0] b);
        logic [31:0] r;
        int s;
        r = '0;
        for (int orow = 0; orow < 2; orow++)
            for (int ocol = 0; ocol < 2; ocol++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(a[((orow+i)*4 + ocol + j)*8 +: 8]) * int'(b[(i*3+j)*8 +: 8]);
                r[(orow*2+ocol)*8 +: 8] = (s > 255) ? 8'hFF : 8'(s);
            end
        return r;
    endfunction

    function automatic logic [31:0] outs();
        return {c22_o, c21_o, c12_o, c11_o};
    endfunction

    // One computation. inj_start: MAC cycle at which a spurious start (with
    // a_i=0) is driven; rst_at: MAC cycle at which reset aborts the run;
    // rnd_ack: random active_store_i during MAC; hold: cycles done is held.
    task automatic run(input string nm, input logic [127:0] a, input logic [71:0] b,
                       input int inj_start, input int rst_at, input bit rnd_ack, input int hold);
        int cyc, bcnt;
        logic [31:0] exp;
        exp = ref_conv(a, b);
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i = {$urandom, $urandom, $urandom, $urandom};
        b_i = {$urandom, $urandom, $urandom};
        cyc = 0; bcnt = 0;
        while (!done_o && cyc < 100) begin
            if (busy_o) bcnt++;
            if (cyc == rst_at) begin
                reset = 1'b1;
                #1;
                chk({nm, "_rst_busy"}, 32'(busy_o), 0);
                chk({nm, "_rst_done"}, 32'(done_o), 0);
                chk({nm, "_rst_c"}, outs(), 0);
                @(negedge clk);
                reset = 1'b0;
                active_store_i = 1'b0;
                @(negedge clk);
                chk({nm, "_post_rst_busy"}, 32'(busy_o), 0);
                return;
            end
            start_i = (cyc == inj_start);
            if (cyc == inj_start) a_i = '0;
            active_store_i = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        active_store_i = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 36);
        chk({nm, "_busy_cycles"}, 32'(bcnt), 36);
        chk({nm, "_busy_in_done"}, 32'(busy_o), 0);
        chk({nm, "_c"}, outs(), exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, "_done_held"}, 32'(done_o), 1);
        end
        // Ack together with a start: start must be ignored on the DONE->IDLE edge.
        active_store_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        active_store_i = 1'b0;
        start_i = 1'b0;
        chk({nm, "_done_drop"}, 32'(done_o), 0);
        chk({nm, "_idle_busy"}, 32'(busy_o), 0);
        @(negedge clk);
        chk({nm, "_no_restart"}, 32'(busy_o), 0);
        chk({nm, "_c_kept"}, outs(), exp);
    endtask

    logic [127:0] a_ones, a_seq, a_max, ra;
    logic [71:0]  b_ones, b_ctr, b_max, rb;

    initial begin
        reset = 1'b1; start_i = 1'b0; active_store_i = 1'b0;
        a_i = '0; b_i = '0;
        for (int k = 0; k < 16; k++) begin
            a_ones[k*8 +: 8] = 8'd1;
            a_seq[k*8 +: 8]  = 8'(k + 1);
            a_max[k*8 +: 8]  = 8'hFF;
        end
        for (int k = 0; k < 9; k++) begin
            b_ones[k*8 +: 8] = 8'd1;
            b_ctr[k*8 +: 8]  = (k == 4) ? 8'd1 : 8'd0;
            b_max[k*8 +: 8]  = 8'hFF;
        end
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_c", outs(), 0);
        reset = 1'b0;

        run("ones",   a_ones, b_ones, -1, -1, 1'b0, 0);
        chk("ones_abs", outs(), 32'h09090909);
        run("center", a_seq,  b_ctr,  -1, -1, 1'b0, 1);
        chk("center_abs", outs(), {8'd11, 8'd10, 8'd7, 8'd6});
        run("sat",    a_max,  b_max,  -1, -1, 1'b0, 0);
        chk("sat_abs", outs(), 32'hFFFFFFFF);
        run("inj",    a_ones, b_ones, 10, -1, 1'b0, 5);
        chk("inj_abs", outs(), 32'h09090909);
        run("abort",  a_max,  b_ones, -1, 20, 1'b0, 0);
        run("after_rst", a_seq, b_ctr, -1, -1, 1'b0, 0);
        chk("after_rst_abs", outs(), {8'd11, 8'd10, 8'd7, 8'd6});

        for (int n = 0; n < 8; n++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            // Small operands on odd runs so results are not all saturated.
            if (n[0]) begin
                for (int k = 0; k < 16; k++) ra[k*8 +: 8] = ra[k*8 +: 8] & 8'h0F;
                for (int k = 0; k < 9; k++)  rb[k*8 +: 8] = rb[k*8 +: 8] & 8'h07;
            end
            run("rand", ra, rb, -1, -1, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
